iterative_shifter: RTL and testbench
====================================

# iterative_shifter

Parametrised multi-cycle shift unit for the MIPS datapaths; the successor to the fixed combinational shift-left-by-2 stage. Performs logical left, logical right, arithmetic right and (optionally) rotate-right by a run-time shift amount, consuming at most STEP bit positions per clock. A start/done handshake lets the multicycle controller issue SLL/SRL/SRA/SLLV/SRLV/SRAV and poll for completion, trading latency for area.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 4
- STEP, 1, maximum bit positions shifted per cycle; power of two, 1..WIDTH
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR
- data_in  input  WIDTH  operand, sampled on accept
- shamt  input  SHAMT_W  shift amount, sampled on accept
- ready  output  1  unit can accept start this cycle
- busy  output  1  shift in progress
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  shifted value; held until next accept

## Operation
- States: IDLE, SHIFT, DONE.
- Accept = start & ready. ready = (state==IDLE) | (state==DONE). start in SHIFT is ignored (not queued).
- On accept: latch op, data_in into work register, remaining <= shamt. Next state SHIFT if shamt≠0, else DONE.
- SHIFT, each edge: n = min(STEP, remaining); work <= step(work, op, n); remaining <= remaining − n. When remaining − n == 0 → DONE.
- Step rules: SLL fills zeros at LSBs; SRL fills zeros at MSBs; SRA fills with work[WIDTH−1] (current sign, equal to original sign); ROTR moves LSBs to MSBs. All arithmetic modulo WIDTH bits, no carry-out.
- DONE: done=1, result = work. Next edge: accept → reload (back-to-back), else IDLE.
- busy = (state==SHIFT).
- result register updates only on DONE entry; stable in IDLE.

## Timing
- Reset (async, any state): state IDLE, ready=1, busy=0, done=0, result=0, work=0, remaining=0.
- Latency, start-accept cycle = cycle 0: done high in cycle 1 + ceil(shamt/STEP). shamt=0 → done in cycle 1.
- Throughput: one op per 1 + ceil(shamt/STEP) cycles with back-to-back start held in DONE.
- done is exactly one cycle wide per accepted op.
- Reset asserted mid-SHIFT aborts op; no done pulse for it; deassert → IDLE, ready next cycle.
- start held high continuously: accepted at IDLE and at each DONE only.

## Configuration
- Macro ITERATIVE_SHIFTER_ROTATE_EN.
- Defined: op=11 performs rotate-right as above.
- Undefined: rotate logic not built; op=11 treated as shamt=0 → result = data_in, done in cycle 1.

## Structure
- Package shifter_pkg: op codes (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROTR=2'b11), state encoding typedef.
- Sub-module shift_step: combinational single-step shifter, inputs work, op, n (0..STEP); instantiated once in iterative_shifter.
- remaining counter width SHAMT_W; n computed from remaining vs STEP.

## Test plan
- WIDTH=32, STEP=1: SLL data_in=32'h0000_0001, shamt=2 → done in cycle 3, result=32'h0000_0004.
- STEP=1: SRA data_in=32'h8000_0000, shamt=4 → done cycle 5, result=32'hF800_0000; SRL same input → 32'h0800_0000.
- STEP=4: SLL data_in=32'h0000_000C, shamt=31 → done cycle 9, result=32'h0000_0000; shamt=0 → done cycle 1, result=32'h0000_000C.
- ROTR (macro defined) data_in=32'h0000_0001, shamt=1 → 32'h8000_0000; macro undefined → 32'h0000_0001, done cycle 1.
- Back-to-back: start held high, two SLL ops shamt=3 (STEP=1) → done pulses in cycles 4 and 8, ready low cycles 1–3 and 5–7; start during SHIFT ignored.
- rst pulsed in cycle 2 of a shamt=10 op → busy=0, done=0, result=0 immediately; no done pulse; ready=1 after release.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared op codes and FSM state encoding for the iterative shifter.
// No logic; constants and types only.
// Imported by iterative_shifter and shift_step.
package shifter_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Single-step shifter: moves work by n (0..STEP) positions according to op.
// Purely combinational, zero latency.
// No flow control; rotate path exists only with ITERATIVE_SHIFTER_ROTATE_EN.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]            work,
    input  logic [1:0]                  op,
    input  logic [$clog2(STEP+1)-1:0]   n,
    output logic [WIDTH-1:0]            shifted
);

    always_comb begin
        shifted = work;
        case (op)
            OP_SLL:  shifted = work << n;
            OP_SRL:  shifted = work >> n;
            OP_SRA:  shifted = $signed(work) >>> n;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
            OP_ROTR: shifted = (work >> n) | (work << (WIDTH - 32'(n)));
`endif
            default: shifted = work;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA (ROTR with ITERATIVE_SHIFTER_ROTATE_EN) shifting at most STEP bits per clock.
// Latency: done pulses 1 + ceil(shamt/STEP) cycles after accept.
// Backpressure: ready only in IDLE/DONE; start while busy is dropped, not queued.
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int NW = $clog2(STEP + 1);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   stepped;
    logic [SHAMT_W-1:0] remaining;
    logic [SHAMT_W-1:0] rem_nxt;
    logic [SHAMT_W-1:0] shamt_eff;
    logic [NW-1:0]      n;
    logic               accept;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    assign shamt_eff = shamt;
`else
    // Without the rotator, ROTR degenerates to a zero-length shift (pass-through).
    assign shamt_eff = (op == OP_ROTR) ? '0 : shamt;
`endif

    assign n       = (32'(remaining) >= STEP) ? NW'(STEP) : NW'(remaining);
    assign rem_nxt = remaining - SHAMT_W'(n);
    assign accept  = start & ready;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .work    (work),
        .op      (op_q),
        .n       (n),
        .shifted (stepped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = (shamt_eff == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (rem_nxt == '0) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
                if (start) state_nxt = (shamt_eff == '0) ? ST_DONE : ST_SHIFT;
                else       state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // result is loaded only on the edge entering DONE so it holds through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_SLL;
            work      <= '0;
            remaining <= '0;
            result    <= '0;
        end else if (accept) begin
            op_q      <= op;
            work      <= data_in;
            remaining <= shamt_eff;
            if (shamt_eff == '0) result <= data_in;
        end else if (state == ST_SHIFT) begin
            work      <= stepped;
            remaining <= rem_nxt;
            if (rem_nxt == '0) result <= stepped;
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Bench for iterative_shifter: STEP=1 and STEP=4 instances against a latency/result model.
module tb_iterative_shifter;

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        start_s [2];
    logic [1:0]  op_s    [2];
    logic [31:0] din_s   [2];
    logic [4:0]  sh_s    [2];
    logic        ready_s [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [31:0] res_s   [2];

    iterative_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .op(op_s[0]),
        .data_in(din_s[0]), .shamt(sh_s[0]), .ready(ready_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0])
    );

    iterative_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .op(op_s[1]),
        .data_in(din_s[1]), .shamt(sh_s[1]), .ready(ready_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1])
    );

    int errors = 0;
    int checks = 0;

    // Model: per unit, whether an op is in flight, cycles left until its done, and results.
    bit          m_busy [2] = '{0, 0};
    bit          m_done [2] = '{0, 0};
    int          m_cnt  [2] = '{0, 0};
    logic [31:0] m_res  [2] = '{0, 0};
    logic [31:0] m_pend [2] = '{0, 0};

    function automatic int step_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int s);
        case (op)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $signed(d) >>> s;
            default: return ROT_EN ? ((d >> s) | (d << (32 - s))) : d;
        endcase
    endfunction

    function automatic int ref_lat(input int u, input logic [1:0] op, input int s);
        if (op == 2'b11 && !ROT_EN) return 1;
        return 1 + (s + step_of(u) - 1) / step_of(u);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_loop();
        int l;
        forever begin
            @(posedge clk);
            for (int u = 0; u < 2; u++) begin
                if (rst_s[u]) begin
                    m_busy[u] = 0; m_done[u] = 0; m_cnt[u] = 0; m_res[u] = '0;
                end else if (m_busy[u]) begin
                    m_cnt[u]--;
                    if (m_cnt[u] == 0) begin
                        m_busy[u] = 0; m_done[u] = 1; m_res[u] = m_pend[u];
                    end
                end else begin
                    m_done[u] = 0;
                    if (start_s[u]) begin
                        l         = ref_lat(u, op_s[u], int'(sh_s[u]));
                        m_pend[u] = ref_shift(op_s[u], din_s[u], int'(sh_s[u]));
                        if (l == 1) begin
                            m_done[u] = 1; m_res[u] = m_pend[u];
                        end else begin
                            m_busy[u] = 1; m_cnt[u] = l - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("u%0d_ready", u), 32'(ready_s[u]), rst_s[u] ? 32'd1 : 32'(!m_busy[u]));
                chk($sformatf("u%0d_busy", u),  32'(busy_s[u]),  rst_s[u] ? 32'd0 : 32'(m_busy[u]));
                chk($sformatf("u%0d_done", u),  32'(done_s[u]),  rst_s[u] ? 32'd0 : 32'(m_done[u]));
                chk($sformatf("u%0d_result", u), res_s[u],       rst_s[u] ? 32'd0 : m_res[u]);
            end
        end
    endtask

    task automatic run_op(input int u, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int lat;
        @(posedge clk); #1;
        start_s[u] = 1'b1; op_s[u] = op; din_s[u] = d; sh_s[u] = s;
        @(posedge clk); #1;
        start_s[u] = 1'b0;
        lat = 1;
        while (done_s[u] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, res_s[u], exp_res);
    endtask

    initial begin
        int seen;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b0; start_s[u] = 1'b0; op_s[u] = 2'b00; din_s[u] = '0; sh_s[u] = '0;
        end
        #2;
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        fork
            model_loop();
            compare_loop();
        join_none

        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset_ready_u%0d", u),  32'(ready_s[u]), 32'd1);
            chk($sformatf("reset_busy_u%0d", u),   32'(busy_s[u]),  32'd0);
            chk($sformatf("reset_done_u%0d", u),   32'(done_s[u]),  32'd0);
            chk($sformatf("reset_result_u%0d", u), res_s[u],        32'd0);
        end

        run_op(0, 2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 3, "sll1");
        run_op(0, 2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000, 5, "sra1");
        run_op(0, 2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000, 5, "srl1");
        run_op(0, 2'b11, 32'h0000_0001, 5'd1,  ROT_EN ? 32'h8000_0000 : 32'h0000_0001, ROT_EN ? 2 : 1, "rotr1");
        run_op(1, 2'b00, 32'h0000_000C, 5'd31, 32'h0000_0000, 9, "sll4_31");
        run_op(1, 2'b00, 32'h0000_000C, 5'd0,  32'h0000_000C, 1, "sll4_0");
        run_op(1, 2'b10, 32'h8000_0000, 5'd7,  32'hFF00_0000, 3, "sra4_7");

        // Back-to-back with start held high: second op loaded while in DONE.
        @(posedge clk); #1;
        start_s[0] = 1'b1; op_s[0] = 2'b00; din_s[0] = 32'h0000_0003; sh_s[0] = 5'd3;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ready_c%0d", c), 32'(ready_s[0]), (c == 4 || c == 8) ? 32'd1 : 32'd0);
            chk($sformatf("b2b_done_c%0d", c),  32'(done_s[0]),  (c == 4 || c == 8) ? 32'd1 : 32'd0);
            if (c == 4) begin
                chk("b2b_result_first", res_s[0], 32'h0000_0018);
                din_s[0] = 32'h0000_0005;
            end
            if (c == 8) begin
                chk("b2b_result_second", res_s[0], 32'h0000_0028);
                start_s[0] = 1'b0;
            end
        end

        // Reset in cycle 2 of a long op aborts it without a done pulse.
        @(posedge clk); #1;
        start_s[0] = 1'b1; op_s[0] = 2'b00; din_s[0] = 32'h0000_1234; sh_s[0] = 5'd10;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        @(posedge clk); #1;
        rst_s[0] = 1'b1;
        #1;
        chk("midrst_busy",   32'(busy_s[0]),  32'd0);
        chk("midrst_done",   32'(done_s[0]),  32'd0);
        chk("midrst_result", res_s[0],        32'd0);
        chk("midrst_ready",  32'(ready_s[0]), 32'd1);
        @(posedge clk); #1;
        rst_s[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (c == 0) chk("postrst_ready", 32'(ready_s[0]), 32'd1);
            if (done_s[0] === 1'b1) seen++;
        end
        chk("postrst_no_done", 32'(seen), 32'd0);

        // Random traffic on both units, with occasional one-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                rst_s[u]   = ($urandom_range(0, 199) == 0);
                start_s[u] = ($urandom_range(0, 3) != 0);
                op_s[u]    = 2'($urandom_range(0, 3));
                din_s[u]   = $urandom;
                case ($urandom_range(0, 3))
                    0:       sh_s[u] = 5'd0;
                    1:       sh_s[u] = 5'd31;
                    default: sh_s[u] = 5'($urandom_range(0, 31));
                endcase
            end
        end
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b0; start_s[u] = 1'b0;
        end
        repeat (40) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
